// File: rtl/mc_controller.sv
// Multi-cycle MIPS control sequencer: IF/DCD/EXE/MEM/WB FSM driving the shared datapath.
// Outputs are decoded combinationally from state and IR fields; only state and the MEM wait counter are registered.
module mc_controller #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int TMO_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] fc,
  input  logic [4:0] rt,
  input  logic       br_eq,
  input  logic       br_ge,
  input  logic       mem_ack,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       alu_src1,
  output logic       alu_src2,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic [2:0] npc_sel,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       lb,
  output logic       sb,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_tmo
);

  typedef enum logic [2:0] {
    stIf  = 3'd0,
    stDcd = 3'd1,
    stExe = 3'd2,
    stMem = 3'd3,
    stWb  = 3'd4
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BGEZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Timeout fires on the wait cycle whose increment would make the counter reach 2**TMO_W-1.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);

  stateT            cur, nxt;
  logic [TMO_W-1:0] waitCnt;

  logic isRType, isAddu, isSubu, isSlt, isSltu, isSll, isJr;
  logic isOri, isAddi, isLui, isLw, isSw, isLb, isSb;
  logic isBeq, isBgez, isJ, isJal;
  logic isAluR, isLoad, isStore, isLegal, memDone;

  assign isRType = (op == OP_RTYPE);
  assign isAddu  = isRType && (fc == 6'h21);
  assign isSubu  = isRType && (fc == 6'h23);
  assign isSlt   = isRType && (fc == 6'h2A);
  assign isSltu  = isRType && (fc == 6'h2B);
  assign isSll   = isRType && (fc == 6'h00);
  assign isJr    = isRType && (fc == 6'h08);
  assign isOri   = (op == OP_ORI);
  assign isAddi  = (op == OP_ADDI);
  assign isLui   = (op == OP_LUI);
  assign isLw    = (op == OP_LW);
  assign isSw    = (op == OP_SW);
  assign isLb    = (op == OP_LB);
  assign isSb    = (op == OP_SB);
  assign isBeq   = (op == OP_BEQ);
  assign isBgez  = (op == OP_BGEZ) && (rt == 5'b00001);
  assign isJ     = (op == OP_J);
  assign isJal   = (op == OP_JAL);

  assign isAluR  = isAddu || isSubu || isSlt || isSltu || isSll;
  assign isLoad  = isLw || isLb;
  assign isStore = isSw || isSb;
  assign isLegal = isAluR || isJr || isOri || isAddi || isLui || isLoad || isStore
                 || isBeq || isBgez || isJ || isJal;
  assign memDone = (MEM_HANDSHAKE == 0) || mem_ack;

  assign state = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= stIf;
      waitCnt <= '0;
    end else begin
      cur     <= nxt;
      waitCnt <= (cur == stMem && nxt == stMem) ? waitCnt + 1'b1 : '0;
    end
  end

  // Reset gates every control output so an abandoned instruction cannot write anything.
  always_comb begin
    nxt        = cur;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    alu_src1   = 1'b0;
    alu_src2   = 1'b0;
    ext_op     = 2'b00;
    alu_op     = 3'b000;
    npc_sel    = 3'b000;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    lb         = 1'b0;
    sb         = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    mem_tmo    = 1'b0;
    if (!reset) begin
      case (cur)
        stIf: begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
          nxt   = stDcd;
        end
        stDcd: begin
          if (isJ) begin
            pc_wr      = 1'b1;
            npc_sel    = 3'b010;
            instr_done = 1'b1;
            nxt        = stIf;
          end else if (isJal) begin
            pc_wr   = 1'b1;
            npc_sel = 3'b010;
            nxt     = stWb;
          end else if (isJr) begin
            pc_wr      = 1'b1;
            npc_sel    = 3'b011;
            instr_done = 1'b1;
            nxt        = stIf;
          end else if (!isLegal) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            nxt        = stIf;
          end else begin
            nxt = stExe;
          end
        end
        stExe: begin
          nxt = stWb;
          if (isSubu)      alu_op = 3'b001;
          else if (isSlt)  alu_op = 3'b101;
          else if (isSltu) alu_op = 3'b100;
          else if (isSll) begin
            alu_op   = 3'b011;
            alu_src1 = 1'b1;
            alu_src2 = 1'b1;
          end else if (isOri) begin
            alu_op   = 3'b010;
            alu_src2 = 1'b1;
          end else if (isAddi || isLoad || isStore) begin
            alu_src2 = 1'b1;
            ext_op   = 2'b01;
          end else if (isLui) begin
            alu_src2 = 1'b1;
            ext_op   = 2'b10;
          end
          if (isLoad || isStore) nxt = stMem;
          if (isBeq) begin
            pc_wr      = br_eq;
            npc_sel    = 3'b001;
            instr_done = 1'b1;
            nxt        = stIf;
          end else if (isBgez) begin
            pc_wr      = br_ge;
            npc_sel    = 3'b100;
            instr_done = 1'b1;
            nxt        = stIf;
          end
        end
        stMem: begin
          mem_rd = isLoad;
          mem_wr = isStore;
          lb     = isLb;
          sb     = isSb;
          if (memDone) begin
            if (isLoad) begin
              nxt = stWb;
            end else begin
              instr_done = 1'b1;
              nxt        = stIf;
            end
          end else if (waitCnt == TMO_LAST) begin
            mem_tmo    = 1'b1;
            instr_done = 1'b1;
            nxt        = stIf;
          end
        end
        stWb: begin
          reg_wr     = 1'b1;
          instr_done = 1'b1;
          nxt        = stIf;
          if (isJal) begin
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end else if (isLoad) begin
            mem_to_reg = 2'b01;
          end else if (isRType) begin
            reg_dst = 2'b01;
          end
        end
        default: nxt = stIf;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: default instance (TMO_W=4) plus a TMO_W=2 instance for timeout cases.
module tb_mc_controller;

  typedef struct packed {
    logic [2:0] state;
    logic       pcWr, irWr, regWr, memRd, memWr, src1, src2;
    logic [1:0] ext;
    logic [2:0] aluOp, npc;
    logic [1:0] regDst, m2r;
    logic       lb, sb, done, ill, tmo;
  } ctrlT;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] op, fc;
  logic [4:0] rt;
  logic brEq, brGe, memAck;

  logic aPcWr, aIrWr, aRegWr, aMemRd, aMemWr, aSrc1, aSrc2, aLb, aSb, aDone, aIll, aTmo;
  logic [1:0] aExt, aRegDst, aM2r;
  logic [2:0] aAluOp, aNpc, aState;
  logic tPcWr, tIrWr, tRegWr, tMemRd, tMemWr, tSrc1, tSrc2, tLb, tSb, tDone, tIll, tTmo;
  logic [1:0] tExt, tRegDst, tM2r;
  logic [2:0] tAluOp, tNpc, tState;

  ctrlT obsA, obsT;
  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  mc_controller #(.MEM_HANDSHAKE(1), .TMO_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .fc(fc), .rt(rt), .br_eq(brEq), .br_ge(brGe),
    .mem_ack(memAck), .pc_wr(aPcWr), .ir_wr(aIrWr), .reg_wr(aRegWr), .mem_rd(aMemRd),
    .mem_wr(aMemWr), .alu_src1(aSrc1), .alu_src2(aSrc2), .ext_op(aExt), .alu_op(aAluOp),
    .npc_sel(aNpc), .reg_dst(aRegDst), .mem_to_reg(aM2r), .lb(aLb), .sb(aSb),
    .state(aState), .instr_done(aDone), .illegal(aIll), .mem_tmo(aTmo)
  );

  mc_controller #(.MEM_HANDSHAKE(1), .TMO_W(2)) dutT (
    .clk(clk), .reset(reset), .op(op), .fc(fc), .rt(rt), .br_eq(brEq), .br_ge(brGe),
    .mem_ack(memAck), .pc_wr(tPcWr), .ir_wr(tIrWr), .reg_wr(tRegWr), .mem_rd(tMemRd),
    .mem_wr(tMemWr), .alu_src1(tSrc1), .alu_src2(tSrc2), .ext_op(tExt), .alu_op(tAluOp),
    .npc_sel(tNpc), .reg_dst(tRegDst), .mem_to_reg(tM2r), .lb(tLb), .sb(tSb),
    .state(tState), .instr_done(tDone), .illegal(tIll), .mem_tmo(tTmo)
  );

  assign obsA = {aState, aPcWr, aIrWr, aRegWr, aMemRd, aMemWr, aSrc1, aSrc2, aExt, aAluOp,
                 aNpc, aRegDst, aM2r, aLb, aSb, aDone, aIll, aTmo};
  assign obsT = {tState, tPcWr, tIrWr, tRegWr, tMemRd, tMemWr, tSrc1, tSrc2, tExt, tAluOp,
                 tNpc, tRegDst, tM2r, tLb, tSb, tDone, tIll, tTmo};

  localparam ctrlT ZERO = '0;
  localparam ctrlT IFW  = '{state:3'd0, pcWr:1'b1, irWr:1'b1, default:'0};
  localparam ctrlT DCDW = '{state:3'd1, default:'0};
  localparam ctrlT EXEW = '{state:3'd2, default:'0};
  localparam ctrlT MEMX = '{state:3'd2, src2:1'b1, ext:2'b01, default:'0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ck(input string tag, input bit useT, input ctrlT exp);
    ctrlT obs;
    #2;
    obs = useT ? obsT : obsA;
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%07h expected=%07h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; op = '0; fc = '0; rt = '0; brEq = 1'b0; brGe = 1'b0; memAck = 1'b0;
    tick(); tick();
    ck("rst_a", 1'b0, ZERO);
    ck("rst_t", 1'b1, ZERO);

    // addu: IF, DCD, EXE, WB
    tick(); reset = 1'b0; op = 6'h00; fc = 6'h21; ck("addu_if", 1'b0, IFW);
    tick(); ck("addu_dcd", 1'b0, DCDW);
    tick(); ck("addu_exe", 1'b0, EXEW);
    tick(); ck("addu_wb", 1'b0, '{state:3'd4, regWr:1'b1, regDst:2'b01, done:1'b1, default:'0});

    // beq taken then not taken
    tick(); op = 6'h04; brEq = 1'b1; ck("beq1_if", 1'b0, IFW);
    tick(); ck("beq1_dcd", 1'b0, DCDW);
    tick(); ck("beq1_exe", 1'b0, '{state:3'd2, pcWr:1'b1, npc:3'b001, done:1'b1, default:'0});
    tick(); brEq = 1'b0; ck("beq0_if", 1'b0, IFW);
    tick(); ck("beq0_dcd", 1'b0, DCDW);
    tick(); ck("beq0_exe", 1'b0, '{state:3'd2, npc:3'b001, done:1'b1, default:'0});

    // bgez (rt=1) taken, then op 1 with rt=0 is undecoded
    tick(); op = 6'h01; rt = 5'd1; brGe = 1'b1;
    tick(); ck("bgez_dcd", 1'b0, DCDW);
    tick(); ck("bgez_exe", 1'b0, '{state:3'd2, pcWr:1'b1, npc:3'b100, done:1'b1, default:'0});
    tick(); rt = 5'd0; brGe = 1'b0;
    tick(); ck("bgez_rt0_ill", 1'b0, '{state:3'd1, ill:1'b1, done:1'b1, default:'0});

    // ori, lui, sll
    tick(); op = 6'h0D; ck("ori_if", 1'b0, IFW);
    tick();
    tick(); ck("ori_exe", 1'b0, '{state:3'd2, src2:1'b1, aluOp:3'b010, default:'0});
    tick(); ck("ori_wb", 1'b0, '{state:3'd4, regWr:1'b1, done:1'b1, default:'0});
    tick(); op = 6'h0F;
    tick();
    tick(); ck("lui_exe", 1'b0, '{state:3'd2, src2:1'b1, ext:2'b10, default:'0});
    tick();
    tick(); op = 6'h00; fc = 6'h00;
    tick();
    tick(); ck("sll_exe", 1'b0, '{state:3'd2, src1:1'b1, src2:1'b1, aluOp:3'b011, default:'0});
    tick(); ck("sll_wb", 1'b0, '{state:3'd4, regWr:1'b1, regDst:2'b01, done:1'b1, default:'0});

    // lw with ack after 3 waits; the TMO_W=2 instance times out on the 3rd wait
    tick(); op = 6'h23; ck("lw_if", 1'b0, IFW);
    tick(); ck("lw_dcd", 1'b0, DCDW);
    tick(); ck("lw_exe", 1'b0, MEMX);
    tick(); ck("lw_w1", 1'b0, '{state:3'd3, memRd:1'b1, default:'0});
    tick(); ck("lw_w2", 1'b0, '{state:3'd3, memRd:1'b1, default:'0});
    tick(); ck("lw_w3", 1'b0, '{state:3'd3, memRd:1'b1, default:'0});
    ck("lw_w3_tmo_t", 1'b1, '{state:3'd3, memRd:1'b1, tmo:1'b1, done:1'b1, default:'0});
    tick(); memAck = 1'b1; ck("lw_ack", 1'b0, '{state:3'd3, memRd:1'b1, default:'0});
    tick(); memAck = 1'b0;
    ck("lw_wb", 1'b0, '{state:3'd4, regWr:1'b1, m2r:2'b01, done:1'b1, default:'0});

    // j, jal, jr, undecoded op and fc
    tick(); op = 6'h02; ck("j_if", 1'b0, IFW);
    tick(); ck("j_dcd", 1'b0, '{state:3'd1, pcWr:1'b1, npc:3'b010, done:1'b1, default:'0});
    tick(); op = 6'h03; ck("jal_if", 1'b0, IFW);
    tick(); ck("jal_dcd", 1'b0, '{state:3'd1, pcWr:1'b1, npc:3'b010, default:'0});
    tick(); ck("jal_wb", 1'b0,
               '{state:3'd4, regWr:1'b1, regDst:2'b10, m2r:2'b10, done:1'b1, default:'0});
    tick(); op = 6'h00; fc = 6'h08;
    tick(); ck("jr_dcd", 1'b0, '{state:3'd1, pcWr:1'b1, npc:3'b011, done:1'b1, default:'0});
    tick(); op = 6'h3F;
    tick(); ck("ill_op", 1'b0, '{state:3'd1, ill:1'b1, done:1'b1, default:'0});
    tick(); ck("ill_back_if", 1'b0, IFW);
    op = 6'h00; fc = 6'h3F;
    tick(); ck("ill_fc", 1'b0, '{state:3'd1, ill:1'b1, done:1'b1, default:'0});

    // sb on TMO_W=2: timeout on 3rd wait, then ack on 3rd cycle wins over timeout
    tick(); reset = 1'b1; ck("rst2_t", 1'b1, ZERO);
    tick(); reset = 1'b0; op = 6'h28; ck("sb_if", 1'b1, IFW);
    tick(); ck("sb_dcd", 1'b1, DCDW);
    tick(); ck("sb_exe", 1'b1, MEMX);
    tick(); ck("sb_w1", 1'b1, '{state:3'd3, memWr:1'b1, sb:1'b1, default:'0});
    tick(); ck("sb_w2", 1'b1, '{state:3'd3, memWr:1'b1, sb:1'b1, default:'0});
    tick(); ck("sb_tmo", 1'b1, '{state:3'd3, memWr:1'b1, sb:1'b1, tmo:1'b1, done:1'b1, default:'0});
    tick(); ck("sb_tmo_if", 1'b1, IFW);
    tick();
    tick();
    tick(); ck("sb2_w1", 1'b1, '{state:3'd3, memWr:1'b1, sb:1'b1, default:'0});
    tick();
    tick(); memAck = 1'b1;
    ck("sb2_ack_wins", 1'b1, '{state:3'd3, memWr:1'b1, sb:1'b1, done:1'b1, default:'0});
    tick(); memAck = 1'b0; ck("sb2_if", 1'b1, IFW);

    // reset in MEM of sw abandons the store
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; op = 6'h2B;
    tick();
    tick();
    tick(); ck("sw_mem", 1'b0, '{state:3'd3, memWr:1'b1, default:'0});
    tick(); reset = 1'b1; ck("sw_rst", 1'b0, ZERO);
    tick(); reset = 1'b0; op = 6'h00; fc = 6'h21; ck("sw_rst_if", 1'b0, IFW);
    tick(); ck("post_rst_dcd", 1'b0, DCDW);
    tick(); ck("post_rst_exe", 1'b0, EXEW);
    tick(); ck("post_rst_wb", 1'b0, '{state:3'd4, regWr:1'b1, regDst:2'b01, done:1'b1, default:'0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
